// File: rtl/cs_window_param.sv
// Sliding-window approximate-average filter: N-deep sample window, running sum,
// and a mean-relative member pick (nearest-below or nearest-above) folded into a scaled sum.
module cs_window_param #(
    parameter int DW    = 8,
    parameter int N     = 9,
    parameter int SHIFT = 3,
    parameter int OW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] X,
    input  logic          mode,
    output logic          y_valid,
    output logic [OW-1:0] Y
);
    // Handshake: in_valid qualifies X and is always consumed (no backpressure) unless
    // reset or clear wins that cycle; y_valid is a one-cycle pulse qualifying a new Y.
    localparam int SW = DW + $clog2(2 * N);
    localparam int TW = SW + 1;
    localparam int FW = $clog2(N + 1);

    logic [DW-1:0] win [N];
    logic [SW-1:0] s_q;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_next;
    logic          pending_q;
    logic          mode_q;

    logic [DW-1:0] a_lo;
    logic [DW-1:0] a_hi;
    logic [DW-1:0] a_sel;
    logic [TW-1:0] t_sum;
    logic [TW-1:0] t_shr;
    logic [OW-1:0] y_next;

    assign fill_next = (fill_q == FW'(N)) ? fill_q : fill_q + FW'(1);

    // Stage 1: window, running sum, fill count, and the pending/mode pair for stage 2.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            for (int i = 0; i < N; i++) win[i] <= '0;
            s_q       <= '0;
            fill_q    <= '0;
            pending_q <= 1'b0;
            mode_q    <= 1'b0;
        end else if (in_valid) begin
            win[0] <= X;
            for (int i = 1; i < N; i++) win[i] <= win[i-1];
            s_q       <= s_q + SW'(X) - SW'(win[N-1]);
            fill_q    <= fill_next;
            pending_q <= (fill_next == FW'(N));
            mode_q    <= mode;
        end else begin
            pending_q <= 1'b0;
        end
    end

    // Comparing Xi*N against S avoids dividing S by N to get the mean.
    always_comb begin
        a_lo = '0;
        a_hi = '1;
        for (int i = 0; i < N; i++) begin
            if ((SW'(win[i]) * SW'(N) <= s_q) && (win[i] >= a_lo)) a_lo = win[i];
            if ((SW'(win[i]) * SW'(N) >= s_q) && (win[i] <= a_hi)) a_hi = win[i];
        end
        a_sel  = mode_q ? a_hi : a_lo;
        t_sum  = TW'(s_q) + TW'(a_sel) * TW'(N);
        t_shr  = t_sum >> SHIFT;
        y_next = ((t_shr >> OW) != '0) ? '1 : OW'(t_shr);
    end

    // Stage 2: Y only moves on a pulse; clear kills an in-flight result but keeps Y.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_valid <= 1'b0;
            Y       <= '0;
        end else if (clear) begin
            y_valid <= 1'b0;
        end else if (pending_q) begin
            y_valid <= 1'b1;
            Y       <= y_next;
        end else begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cs_window_param.sv
// Bench for cs_window_param: three builds (defaults, OW=9, N=3/DW=4/SHIFT=0) share one
// stimulus stream; a per-build scoreboard plus directed checks per scenario.
module tb_cs_window_param;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic       mode;
    logic [7:0] x_d;
    logic [3:0] x_s;

    logic       y_valid_d, y_valid_9, y_valid_s;
    logic [9:0] y_d;
    logic [8:0] y_9;
    logic [9:0] y_s;

    logic [9:0] exp_d[$];
    logic [8:0] exp_9[$];
    logic [9:0] exp_s[$];

    int wd[16];
    int ws[16];
    int fd, fs;
    int pulses_d, pulses_s;
    int tests_run, tests_failed;

    cs_window_param #(.DW(8), .N(9), .SHIFT(3), .OW(10)) dut_d (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .X(x_d),
        .mode(mode), .y_valid(y_valid_d), .Y(y_d));

    cs_window_param #(.DW(8), .N(9), .SHIFT(3), .OW(9)) dut_9 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .X(x_d),
        .mode(mode), .y_valid(y_valid_9), .Y(y_9));

    cs_window_param #(.DW(4), .N(3), .SHIFT(0), .OW(10)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .X(x_s),
        .mode(mode), .y_valid(y_valid_s), .Y(y_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick the member straight from its definition over the first n slots.
    function automatic int model_y(input int n, input int shift, input int ow,
                                   input logic m, input int w[16]);
        int s, a, t;
        s = 0;
        for (int i = 0; i < n; i++) s += w[i];
        a = m ? 32'h3fff_ffff : -1;
        for (int i = 0; i < n; i++) begin
            if (!m && (w[i] * n <= s) && (w[i] > a)) a = w[i];
            if (m && (w[i] * n >= s) && (w[i] < a)) a = w[i];
        end
        t = (s + n * a) >> shift;
        if (t > (1 << ow) - 1) t = (1 << ow) - 1;
        return t;
    endfunction

    // One clock: drive at negedge, update model at posedge, score outputs at next negedge.
    task automatic step(input logic v, input int x, input logic m, input logic clr, input logic rst);
        logic [9:0] e10;
        logic [8:0] e9;
        in_valid = v;
        x_d      = 8'(x);
        x_s      = 4'(x);
        mode     = m;
        clear    = clr;
        reset    = !rst;
        @(posedge clk);
        if (rst || clr) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = 0;
                ws[i] = 0;
            end
            fd = 0;
            fs = 0;
            exp_d.delete();
            exp_9.delete();
            exp_s.delete();
        end else if (v) begin
            for (int i = 15; i > 0; i--) begin
                wd[i] = wd[i-1];
                ws[i] = ws[i-1];
            end
            wd[0] = x & 255;
            ws[0] = x & 15;
            if (fd < 9) fd++;
            if (fs < 3) fs++;
            if (fd == 9) begin
                exp_d.push_back(10'(model_y(9, 3, 10, m, wd)));
                exp_9.push_back(9'(model_y(9, 3, 9, m, wd)));
            end
            if (fs == 3) exp_s.push_back(10'(model_y(3, 0, 10, m, ws)));
        end
        @(negedge clk);
        if (y_valid_d === 1'b1) begin
            pulses_d++;
            tests_run++;
            if (exp_d.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_default: unexpected pulse Y=%0d, no result required", y_d);
            end else begin
                e10 = exp_d.pop_front();
                if (y_d !== e10) begin
                    tests_failed++;
                    $display("FAIL sb_default: Y=%0d required %0d", y_d, e10);
                end
            end
        end
        if (y_valid_9 === 1'b1) begin
            tests_run++;
            if (exp_9.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_ow9: unexpected pulse Y=%0d, no result required", y_9);
            end else begin
                e9 = exp_9.pop_front();
                if (y_9 !== e9) begin
                    tests_failed++;
                    $display("FAIL sb_ow9: Y=%0d required %0d", y_9, e9);
                end
            end
        end
        if (y_valid_s === 1'b1) begin
            pulses_s++;
            tests_run++;
            if (exp_s.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_small: unexpected pulse Y=%0d, no result required", y_s);
            end else begin
                e10 = exp_s.pop_front();
                if (y_s !== e10) begin
                    tests_failed++;
                    $display("FAIL sb_small: Y=%0d required %0d", y_s, e10);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 200 + i, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (y_valid_d !== 1'b0 || y_d !== 10'd0 || y_valid_9 !== 1'b0 || y_9 !== 9'd0 ||
            y_valid_s !== 1'b0 || y_s !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_state: vd=%b yd=%0d v9=%b y9=%0d vs=%b ys=%0d required all 0",
                     y_valid_d, y_d, y_valid_9, y_9, y_valid_s, y_s);
        end
    endtask

    task automatic test_fill();
        int p0;
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        p0 = pulses_d;
        for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (pulses_d !== p0) begin
            tests_failed++;
            $display("FAIL fill_early: pulses=%0d required 0", pulses_d - p0);
        end
        step(1'b1, 9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b1 || y_d !== 10'd11) begin
            tests_failed++;
            $display("FAIL fill_mode0: v=%b Y=%0d required v=1 Y=11", y_valid_d, y_d);
        end
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (pulses_d !== p0 + 1) begin
            tests_failed++;
            $display("FAIL fill_pulses: pulses=%0d required 1", pulses_d - p0);
        end
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) step(1'b1, i, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b1 || y_d !== 10'd11) begin
            tests_failed++;
            $display("FAIL fill_mode1: v=%b Y=%0d required v=1 Y=11", y_valid_d, y_d);
        end
    endtask

    task automatic test_mode_split();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b1 || y_d !== 10'd1) begin
            tests_failed++;
            $display("FAIL split_mode0: v=%b Y=%0d required v=1 Y=1", y_valid_d, y_d);
        end
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b1 || y_d !== 10'd12) begin
            tests_failed++;
            $display("FAIL split_mode1: v=%b Y=%0d required v=1 Y=12", y_valid_d, y_d);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 255, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b1 || y_d !== 10'd573) begin
            tests_failed++;
            $display("FAIL full_scale: v=%b Y=%0d required v=1 Y=573", y_valid_d, y_d);
        end
        tests_run++;
        if (y_valid_9 !== 1'b1 || y_9 !== 9'd511) begin
            tests_failed++;
            $display("FAIL saturate_ow9: v=%b Y=%0d required v=1 Y=511", y_valid_9, y_9);
        end
    endtask

    task automatic test_stalls();
        int p0;
        int exp_st[4];
        logic [9:0] hold;
        exp_st = '{11, 13, 15, 18};
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        p0 = pulses_d;
        hold = y_d;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, i, 1'b0, 1'b0, 1'b0);
            if (i > 9) begin
                tests_run++;
                if (y_valid_d !== 1'b0 || y_d !== hold) begin
                    tests_failed++;
                    $display("FAIL stall_hold: v=%b Y=%0d required v=0 Y=%0d", y_valid_d, y_d, hold);
                end
            end
            step(1'b0, 0, 1'b0, 1'b0, 1'b0);
            if (i >= 9) begin
                tests_run++;
                if (y_valid_d !== 1'b1 || y_d !== 10'(exp_st[i-9])) begin
                    tests_failed++;
                    $display("FAIL stall_value: v=%b Y=%0d required v=1 Y=%0d", y_valid_d, y_d, exp_st[i-9]);
                end
                hold = y_d;
            end
        end
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (pulses_d !== p0 + 4) begin
            tests_failed++;
            $display("FAIL stall_pulses: pulses=%0d required 4", pulses_d - p0);
        end
    endtask

    task automatic test_clear_mid();
        int p0;
        logic [9:0] hold;
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 20 + i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 99, 1'b0, 1'b1, 1'b0);
        p0 = pulses_d;
        for (int i = 0; i < 8; i++) step(1'b1, 30 + i, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (pulses_d !== p0) begin
            tests_failed++;
            $display("FAIL clear_refill: pulses=%0d required 0 after 8 accepts", pulses_d - p0);
        end
        step(1'b1, 40, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_ninth: v=%b required 1", y_valid_d);
        end
        step(1'b1, 7, 1'b0, 1'b0, 1'b0);
        hold = y_d;
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b0 || y_d !== hold) begin
            tests_failed++;
            $display("FAIL clear_inflight: v=%b Y=%0d required v=0 Y=%0d", y_valid_d, y_d, hold);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int i = 0; i < 5; i++) step(1'b1, 60 + i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 50, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (y_valid_d !== 1'b0 || y_d !== 10'd0 || y_valid_9 !== 1'b0 || y_9 !== 9'd0 ||
            y_valid_s !== 1'b0 || y_s !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: vd=%b yd=%0d v9=%b y9=%0d vs=%b ys=%0d required all 0",
                     y_valid_d, y_d, y_valid_9, y_9, y_valid_s, y_s);
        end
        p0 = pulses_d;
        for (int i = 0; i < 8; i++) step(1'b1, 3 * i, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (pulses_d !== p0) begin
            tests_failed++;
            $display("FAIL reset_refill: pulses=%0d required 0", pulses_d - p0);
        end
        step(1'b1, 100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (y_valid_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ninth: v=%b required 1", y_valid_d);
        end
    endtask

    task automatic test_small();
        for (int m = 0; m < 2; m++) begin
            step(1'b0, 0, 1'b0, 1'b1, 1'b0);
            step(1'b1, 1, 1'(m), 1'b0, 1'b0);
            step(1'b1, 2, 1'(m), 1'b0, 1'b0);
            step(1'b1, 15, 1'(m), 1'b0, 1'b0);
            step(1'b0, 0, 1'b0, 1'b0, 1'b0);
            tests_run++;
            if (y_valid_s !== 1'b1 || y_s !== ((m == 0) ? 10'd24 : 10'd63)) begin
                tests_failed++;
                $display("FAIL small_mode%0d: v=%b Y=%0d required v=1 Y=%0d",
                         m, y_valid_s, y_s, (m == 0) ? 24 : 63);
            end
        end
    endtask

    task automatic test_random();
        int p0;
        p0 = pulses_d;
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 4) != 0), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (pulses_d - p0 < 100) begin
            tests_failed++;
            $display("FAIL random_activity: pulses=%0d required at least 100", pulses_d - p0);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (exp_d.size() != 0 || exp_9.size() != 0 || exp_s.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: pending results d=%0d ow9=%0d small=%0d required 0",
                     exp_d.size(), exp_9.size(), exp_s.size());
        end
    endtask

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        x_d      = '0;
        x_s      = '0;
        fd = 0;
        fs = 0;
        pulses_d = 0;
        pulses_s = 0;
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 16; i++) begin
            wd[i] = 0;
            ws[i] = 0;
        end
        test_reset();
        test_fill();
        test_mode_split();
        test_saturation();
        test_stalls();
        test_clear_mid();
        test_reset_mid();
        test_small();
        test_random();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cs_window_param.md
# cs_window_param

Parametrised sliding-window approximate-average filter, the successor to the fixed 9-sample, 8-bit CS block. Each accepted sample enters an N-deep window. The block then emits a scaled sum that combines the window total with a window member selected relative to the window mean. The selection direction is runtime-selectable (nearest-below or nearest-above). The block sits on the sample datapath and adds valid qualification, a flush input, output saturation and a selectable approximation mode, none of which the CS block has.

## Interface
- DW, 8, sample width in bits (4..16)
- N, 9, window depth in samples (3..16)
- SHIFT, 3, output right-shift, i.e. divide by 2^SHIFT (0..8)
- OW, 10, output width in bits
- SW (localparam), DW + clog2(2·N), internal sum width

- clk  input  1  rising-edge clock, single domain
- reset  input  1  synchronous, active-low reset
- clear  input  1  synchronous window flush, active-high
- in_valid  input  1  X is presented this cycle
- X  input  DW  sample, unsigned
- mode  input  1  0 = nearest-below mean, 1 = nearest-above mean
- y_valid  output  1  Y holds a new result, one-cycle pulse
- Y  output  OW  result, unsigned

## Operation
- **Window**
  - N×DW shift register plus a running sum S (SW bits).
  - On accept (in_valid=1, no reset, no clear): S ← S + X − oldest, and the window shifts.
  - Empty slots hold 0.
- **Fill counter**: saturates at N.
- **Result eligibility**: a sample accepted when the fill counter, after the update, equals N produces a result. Earlier accepts produce none.
- **Stage 1** registers, alongside the window, a pending flag and the mode bit, so mode is sampled with its sample.
- **Stage 2** selects A, the approximate value, with no divider; multiply by constant N only:
  - mode 0: A = max{Xi : Xi·N ≤ S}
  - mode 1: A = min{Xi : Xi·N ≥ S}
  - A set of Xi always exists because the mean lies between the window min and max. Ties on equal values are irrelevant to the result.
- **Output value**: T = (S + N·A) >> SHIFT, computed at SW+1 bits.
  - Y = T if T < 2^OW, else 2^OW − 1 (saturate).
- **Priority**: reset > clear > in_valid.
- **clear**
  - Zeroes the window, S, the fill counter and the pending flag.
  - Forces y_valid=0 on the next edge and drops any sample presented in the same cycle.
  - Y holds its last value.
- **in_valid gaps**: neither the window nor the outputs advance. y_valid is 0 in gap cycles.

## Timing
- **Reset values**: window 0, S 0, fill 0, pending 0, y_valid 0, Y 0.
  - Held while reset=0 at an edge, regardless of other inputs.
- **Latency**: a sample accepted at edge k produces Y with y_valid=1 after edge k+1, sampled at edge k+2.
- **y_valid pulse**: high exactly one cycle per eligible accept. Back-to-back accepts give back-to-back pulses.
- **Y retention**: Y is stable between pulses and holds the last value.
- **Post-flush fill**: after reset or clear, the first y_valid follows the N-th accept.
- **Mid-operation reset or clear**: kills a result in flight in stage 1.
- **Throughput**: one sample per cycle sustained.
- **Critical path**: N parallel compares, then the N-way min/max tree, then the adder. Synthesis closes at 10 ns for the default parameters.

## Test plan
- **Fill and basic value**: defaults, mode 0, accept 1..9 consecutively.
  - No y_valid for accepts 1..8.
  - After accept 9: S=45, A=5, Y=(45+45)>>3=11 (0x00B), one pulse.
  - Mode 1 gives 11 as well.
- **Mode split**: window {0,0,0,0,0,0,0,0,10}, S=10.
  - mode 0: A=0, Y=1.
  - mode 1: A=10, Y=(10+90)>>3=12.
  - Toggle mode on the accept cycle only and check that the result follows the sampled mode.
- **Full scale and saturation**: all inputs 0xFF.
  - Defaults: Y=573 (0x23D).
  - Rebuild with OW=9: Y=511 and y_valid still pulses.
- **Stalls**: feed 1..12 with in_valid dropped every other cycle.
  - Exactly 4 pulses, with window sums 45, 54, 63, 72.
  - Y stable during gaps.
- **Flush and reset mid-stream**:
  - Assert clear together with in_valid after 5 accepts. That sample is dropped, no pulse occurs, and the next result appears only after 9 new accepts.
  - Repeat using reset=0 instead of clear: all outputs read 0 after the edge.
- **Parameter sweep**: N=3, DW=4, SHIFT=0, window {1,2,15}, S=18.
  - mode 0: A=2, Y=24.
  - mode 1: A=15, Y=63.
  - Also run a randomized compare against a reference model for 2000 samples in both modes.
